// File: rtl/sensor_pkg.sv
// Shared types and constants for the sensor scan controller: FSM states,
// channel/sample sizing and the ascending channel picker.
package sensor_pkg;
  localparam int NUM_CH_DEF = 4;
  localparam int SAMPLE_W   = 8;
  localparam int MAX_CH     = 8;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_SETTLE, ST_OUTPUT} scan_state_e;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } ch_pick_t;

  // Lowest set mask bit at or above 'from'; found=0 when none remain.
  function automatic ch_pick_t pick_from(input logic [MAX_CH-1:0] mask, input logic [3:0] from);
    ch_pick_t p;
    p = '0;
    for (int i = MAX_CH-1; i >= 0; i--) begin
      if (mask[i] && (4'(i) >= from)) begin
        p.found = 1'b1;
        p.idx   = 3'(i);
      end
    end
    return p;
  endfunction
endpackage

// File: rtl/sensor_scan_ctrl_if.sv
// Sample output handshake: the controller is the master (valid/data/channel),
// the consumer is the slave (ready).
interface sensor_scan_ctrl_if import sensor_pkg::*; #(parameter int CH_W = 2);
  logic                sample_valid;
  logic                sample_ready;
  logic [SAMPLE_W-1:0] sample_data;
  logic [CH_W-1:0]     sample_ch;

  modport master (output sample_valid, sample_data, sample_ch, input sample_ready);
  modport slave  (input sample_valid, sample_data, sample_ch, output sample_ready);
endinterface

// File: rtl/sensor_period_timer.sv
// Free-running scan interval timer: one-cycle registered tick every
// max(period,1) cycles while enabled; cleared whenever enable is low.
module sensor_period_timer #(
  parameter int PERIOD_W = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                enable,
  input  logic [PERIOD_W-1:0] period,
  output logic                tick
);
  logic [PERIOD_W-1:0] cnt;
  logic [PERIOD_W-1:0] last;

  // period 0 behaves as 1, so the terminal count is 0 and tick fires every cycle
  assign last = (period == '0) ? '0 : period - PERIOD_W'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (!enable) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (cnt >= last) begin
      cnt  <= '0;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt + PERIOD_W'(1);
      tick <= 1'b0;
    end
  end
endmodule

// File: rtl/sensor_scan_ctrl.sv
// Periodic multi-channel sensor scanner: on each tick, walk the latched mask in
// ascending order, settle the mux, capture a sample and hand it off.
module sensor_scan_ctrl import sensor_pkg::*; #(
  parameter int NUM_CH        = NUM_CH_DEF,
  parameter int SETTLE_CYCLES = 3,
  parameter int PERIOD_W      = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       enable,
  input  logic [PERIOD_W-1:0]        period,
  input  logic [NUM_CH-1:0]          ch_mask,
  input  logic [SAMPLE_W-1:0]        sensor_data,
  input  logic                       overrun_clr,
  output logic [$clog2(NUM_CH)-1:0]  ch_sel,
  output logic                       busy,
  output logic                       overrun,
  sensor_scan_ctrl_if.master         smp
);
  localparam int CH_W = $clog2(NUM_CH);
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  logic                tick;
  scan_state_e         state;
  logic [NUM_CH-1:0]   mask_q;
  logic [3:0]          settle_cnt;
  logic                valid_q;
  logic [SAMPLE_W-1:0] data_q;
  logic [CH_W-1:0]     ch_q;
  ch_pick_t            first_pick;
  ch_pick_t            next_pick;

  sensor_period_timer #(.PERIOD_W(PERIOD_W)) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .enable  (enable),
    .period  (period),
    .tick    (tick)
  );

  // first channel comes from the live mask (latched on the same edge), later ones from the latch
  assign first_pick = pick_from(MAX_CH'(ch_mask), 4'd0);
  assign next_pick  = pick_from(MAX_CH'(mask_q), 4'(ch_sel) + 4'd1);

  assign smp.sample_valid = valid_q;
  assign smp.sample_data  = data_q;
  assign smp.sample_ch    = ch_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      mask_q     <= '0;
      settle_cnt <= '0;
      ch_sel     <= '0;
      valid_q    <= 1'b0;
      data_q     <= '0;
      ch_q       <= '0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      // a tick landing mid-scan is dropped and flagged; setting wins over clearing
      if (tick && (state == ST_SETTLE || state == ST_OUTPUT)) overrun <= 1'b1;
      else if (overrun_clr)                                   overrun <= 1'b0;

      if (!enable) begin
        state   <= ST_IDLE;
        valid_q <= 1'b0;
        busy    <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: state <= ST_WAIT;
          ST_WAIT: begin
            if (tick && first_pick.found) begin
              mask_q     <= ch_mask;
              ch_sel     <= first_pick.idx[CH_W-1:0];
              settle_cnt <= '0;
              busy       <= 1'b1;
              state      <= ST_SETTLE;
            end
          end
          ST_SETTLE: begin
            if (settle_cnt == SETTLE_LAST) begin
              data_q  <= sensor_data;
              ch_q    <= ch_sel;
              valid_q <= 1'b1;
              state   <= ST_OUTPUT;
            end else begin
              settle_cnt <= settle_cnt + 4'd1;
            end
          end
          ST_OUTPUT: begin
            if (smp.sample_ready) begin
              valid_q <= 1'b0;
              if (next_pick.found) begin
                ch_sel     <= next_pick.idx[CH_W-1:0];
                settle_cnt <= '0;
                state      <= ST_SETTLE;
              end else begin
                busy  <= 1'b0;
                state <= ST_WAIT;
              end
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_sensor_scan_ctrl.sv
// Bench for sensor_scan_ctrl: scan-vector table, directed corner sequences and
// a randomized run against a queue-based reference model.
module tb_sensor_scan_ctrl;
  import sensor_pkg::*;
  localparam int NCH = 4;
  localparam int S   = 3;
  localparam int PW  = 16;
  localparam int CW  = 2;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          enable = 1'b0;
  logic          overrun_clr = 1'b0;
  logic [PW-1:0] period = '0;
  logic [NCH-1:0] ch_mask = '0;
  logic [7:0]    sensor_data = '0;
  logic [CW-1:0] ch_sel;
  logic          busy, overrun;

  sensor_scan_ctrl_if #(.CH_W(CW)) smp_if ();

  sensor_scan_ctrl #(.NUM_CH(NCH), .SETTLE_CYCLES(S), .PERIOD_W(PW)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .period      (period),
    .ch_mask     (ch_mask),
    .sensor_data (sensor_data),
    .overrun_clr (overrun_clr),
    .ch_sel      (ch_sel),
    .busy        (busy),
    .overrun     (overrun),
    .smp         (smp_if)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // ---------------- reference model (scan as a queue of channels) ----------------
  int       m_run;
  bit       m_tick, m_pres;
  int       m_settle;
  bit       m_active;
  int       m_q[$];
  logic       m_valid, m_busy, m_ovr;
  logic [7:0] m_data;
  logic [1:0] m_ch, m_sel;

  task automatic model_reset();
    m_run = 0; m_tick = 0; m_pres = 0; m_settle = 0; m_active = 0; m_q.delete();
    m_valid = 0; m_busy = 0; m_ovr = 0; m_data = '0; m_ch = '0; m_sel = '0;
  endtask

  task automatic model_edge();
    bit tk, busy_pre;
    int p;
    tk = m_tick;
    p = (period == 0) ? 1 : int'(period);
    busy_pre = (m_settle > 0) || m_pres;
    m_run = enable ? m_run + 1 : 0;
    m_tick = enable && (m_run % p == 0);
    if (tk && busy_pre) m_ovr = 1;
    else if (overrun_clr) m_ovr = 0;
    if (!enable) begin
      m_active = 0; m_settle = 0; m_pres = 0; m_valid = 0; m_q.delete();
    end else if (!m_active) begin
      m_active = 1;
    end else if (m_settle > 0) begin
      if (m_settle == 1) begin
        m_settle = 0; m_pres = 1; m_valid = 1; m_data = sensor_data; m_ch = 2'(m_q[0]);
      end else m_settle--;
    end else if (m_pres) begin
      if (smp_if.sample_ready) begin
        m_pres = 0; m_valid = 0;
        void'(m_q.pop_front());
        if (m_q.size() > 0) begin m_sel = 2'(m_q[0]); m_settle = S; end
      end
    end else if (tk) begin
      for (int c = 0; c < NCH; c++) if (ch_mask[c]) m_q.push_back(c);
      if (m_q.size() > 0) begin m_sel = 2'(m_q[0]); m_settle = S; end
    end
    m_busy = (m_settle > 0) || m_pres;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; enable = 1'b0; overrun_clr = 1'b0; smp_if.sample_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  // ---------------- scan vector table ----------------
  typedef struct {
    int         per;
    logic [3:0] mask;
    int         lat;   // edges from enable to first sample_valid: max(per,1)+S+1
    int         n;
    logic [7:0] chs;   // expected channel order, 2 bits each, first in [1:0]
  } vec_t;

  vec_t vt[5];

  initial begin
    int got, ncyc, waitc;
    bit bad;
    logic [1:0] ech;

    vt[0] = '{10, 4'b0101, 14, 2, 8'b00_00_10_00};
    vt[1] = '{5,  4'b1111,  9, 4, 8'b11_10_01_00};
    vt[2] = '{0,  4'b1000,  5, 1, 8'b00_00_00_11};
    vt[3] = '{7,  4'b0110, 11, 2, 8'b00_00_10_01};
    vt[4] = '{2,  4'b1001,  6, 2, 8'b00_00_11_00};

    smp_if.sample_ready = 1'b0;
    @(negedge clk);
    chk("reset_outputs", {smp_if.sample_valid, smp_if.sample_data, smp_if.sample_ch, ch_sel, busy, overrun}, 32'h0);

    for (int v = 0; v < 5; v++) begin
      do_reset();
      period = PW'(vt[v].per); ch_mask = vt[v].mask; smp_if.sample_ready = 1'b1; enable = 1'b1;
      got = 0; ncyc = 0;
      while (got < vt[v].n && ncyc < 200) begin
        sensor_data = 8'h30 + 8'(ch_sel);
        cyc(); ncyc++;
        if (smp_if.sample_valid) begin
          ech = vt[v].chs[2*got +: 2];
          if (got == 0) chk("first_latency", ncyc, vt[v].lat);
          chk("scan_ch", smp_if.sample_ch, ech);
          chk("scan_data", smp_if.sample_data, 8'h30 + 8'(ech));
          got++;
        end
      end
      chk("scan_count", got, vt[v].n);
      enable = 1'b0;
    end

    // stalled consumer: sample frozen, overrun flagged, then async reset in OUTPUT
    do_reset();
    period = 8; ch_mask = 4'b0100; sensor_data = 8'hA5; enable = 1'b1;
    waitc = 0;
    while (!smp_if.sample_valid && waitc < 50) begin cyc(); waitc++; end
    chk("stall_valid_seen", smp_if.sample_valid, 1);
    sensor_data = 8'h11;
    bad = 0;
    repeat (20) begin
      cyc();
      if ({smp_if.sample_valid, smp_if.sample_data, smp_if.sample_ch} !== {1'b1, 8'hA5, 2'd2}) bad = 1;
    end
    chk("stall_stable", bad, 0);
    chk("stall_overrun", overrun, 1);
    chk("stall_busy", busy, 1);
    smp_if.sample_ready = 1'b1;
    cyc();
    smp_if.sample_ready = 1'b0;
    chk("stall_release", {smp_if.sample_valid, busy}, 2'b00);
    waitc = 0;
    while (!smp_if.sample_valid && waitc < 50) begin cyc(); waitc++; end
    chk("next_sample_data", smp_if.sample_data, 8'h11);
    reset_n = 1'b0;
    #1;
    chk("async_reset", {smp_if.sample_valid, smp_if.sample_data, smp_if.sample_ch, ch_sel, busy, overrun}, 32'h0);
    @(negedge clk);

    // empty mask: ticks ignored, no overrun
    do_reset();
    period = 3; ch_mask = 4'b0000; smp_if.sample_ready = 1'b1; enable = 1'b1;
    bad = 0;
    repeat (30) begin
      cyc();
      if ({smp_if.sample_valid, busy, overrun} !== 3'b000) bad = 1;
    end
    chk("mask0_quiet", bad, 0);

    // enable drop during SETTLE of ch1
    do_reset();
    period = 3; ch_mask = 4'b0011; smp_if.sample_ready = 1'b1; enable = 1'b1;
    waitc = 0;
    while (!(busy && !smp_if.sample_valid && ch_sel == 2'd1) && waitc < 100) begin cyc(); waitc++; end
    chk("reach_settle_ch1", waitc < 100, 1);
    chk("pre_drop_overrun", overrun, 1);
    enable = 1'b0;
    cyc();
    chk("drop_idle", {smp_if.sample_valid, busy}, 2'b00);
    chk("drop_overrun_kept", overrun, 1);
    chk("drop_ch_sel_held", ch_sel, 1);

    // period 0: tick every cycle, overrun during first scan, then clear
    do_reset();
    period = 0; ch_mask = 4'b0001; smp_if.sample_ready = 1'b1; enable = 1'b1;
    waitc = 0;
    while (!smp_if.sample_valid && waitc < 50) begin cyc(); waitc++; end
    chk("p0_first_latency", waitc, 5);
    chk("p0_overrun", overrun, 1);
    enable = 1'b0;
    cyc(); cyc();
    overrun_clr = 1'b1;
    cyc();
    overrun_clr = 1'b0;
    chk("p0_overrun_clr", overrun, 0);

    // randomized run against the reference model
    do_reset();
    model_reset();
    for (int i = 0; i < 4000 && failures < 20; i++) begin
      if (enable) enable = ($urandom_range(0, 99) != 0);
      else        enable = ($urandom_range(0, 2) == 0);
      if (!enable) period = PW'($urandom_range(0, 12));
      if ($urandom_range(0, 7) == 0) ch_mask = NCH'($urandom);
      smp_if.sample_ready = ($urandom_range(0, 3) != 0);
      overrun_clr = ($urandom_range(0, 15) == 0);
      sensor_data = 8'($urandom);
      @(posedge clk);
      model_edge();
      @(negedge clk);
      chk("rand_cycle",
          {smp_if.sample_valid, smp_if.sample_data, smp_if.sample_ch, ch_sel, busy, overrun},
          {m_valid, m_data, m_ch, m_sel, m_busy, m_ovr});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
